rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- ID stage of the 32-bit RV32I core, between fetch (IF) and execute (EX).
- Decodes the incoming instruction and drives the register file read addresses combinationally.
- Captures register file read data, sign-extended immediate and control bundle into the ID/EX pipeline register.
- Owns load-use stall detection, bubble insertion and branch flush.

Parameters:
XLEN, 32, datapath/register width
PC_W, 32, program counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  IF holds a valid instruction
if_ready  out  1  ID accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  PC_W  instruction address
rf_rs1  out  5  register file read address 1 (= if_instr[19:15])
rf_rs2  out  5  register file read address 2 (= if_instr[24:20])
rf_rdata1  in  XLEN  register file read data 1, combinational
rf_rdata2  in  XLEN  register file read data 2, combinational
wb_we  in  1  writeback write enable (bypass only)
wb_rd  in  5  writeback destination (bypass only)
wb_data  in  XLEN  writeback data (bypass only)
flush  in  1  branch/jump redirect from EX
ex_ready  in  1  EX accepts the ID/EX contents
ex_valid  out  1  ID/EX register holds a valid instruction
ex_pc  out  PC_W  registered PC
ex_op1  out  XLEN  registered rs1 value
ex_op2  out  XLEN  registered rs2 value
ex_imm  out  XLEN  registered sign-extended immediate
ex_rd  out  5  registered destination register
ex_ctrl  out  CTRL_W  registered control bundle (ctrl_t)
ex_illegal  out  1  registered illegal-opcode flag

Behaviour:
- Reset: ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_ctrl and ex_illegal all go to 0. Reset has priority over flush and handshake. Reset mid-stall drops the stalled instruction.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Any other opcode: ex_illegal=1 and ex_ctrl all-zero, so it does no reg write and no memory access.
- Immediate formats I/S/B/U/J, sign-extended to XLEN. Any other opcode gives imm=0.
- ctrl_t fields: alu_op[3:0], alu_src_imm, op1_pc, reg_write, is_load, is_store, is_branch, is_jump.
- reg_write is forced to 0 when rd==0.
- Source-use flags:
  - use_rs1 for every decoded opcode except LUI, AUIPC and JAL.
  - use_rs2 for BRANCH, STORE and OP.
- x0 handling: the register file does not hardwire x0, so op1 (op2) is forced to 0 when rs1 (rs2) == 0.
- pipe_ready = ex_ready | ~ex_valid.
- Load-use hazard, all of the following true:
  - ex_valid is set, and ex_ctrl.is_load and ex_ctrl.reg_write are set;
  - ex_rd is nonzero;
  - ex_rd == rs1 with use_rs1, or ex_rd == rs2 with use_rs2.
- if_ready = pipe_ready & ~hazard & ~flush.
- Transfer happens when if_valid & if_ready. The ID/EX register then loads the decoded instruction and ex_valid becomes 1 next cycle. Latency is 1 cycle from IF acceptance to ex_valid.
- If pipe_ready and there is no transfer (IF idle, hazard, or flush), ex_valid becomes 0: a bubble. Payload registers may hold stale values.
- If ~pipe_ready, every ex_* output holds.
- flush: ex_valid becomes 0 next cycle regardless of ex_ready. The IF instruction presented that cycle is not accepted. Flush beats hazard and transfer.
- A hazard lasts exactly one bubble cycle per load, provided EX is ready.

Optional Feature:
- Macro DEC_WB_BYPASS_EN.
- Defined: if wb_we and wb_rd == rs (rs != 0), the operand takes wb_data instead of rf_rdata. This covers the same-cycle write/read race in the clocked-write register file. The x0 force still has priority.
- Undefined: wb_* ports exist but are ignored, and operands come from rf_rdata only.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams;
  - ALU op encodings;
  - ctrl_t packed struct and CTRL_W;
  - immediate-format enum.
- One sub-module, rv_decoder: purely combinational, instruction in, ctrl_t/imm/use_rs1/use_rs2/illegal out.
- The parent holds the hazard logic, bypass mux and ID/EX register.

Test Plan:
- ADDI x5,x1,7 (0x00708293), rf_rdata1=10, ex_ready=1 -> next cycle ex_valid=1, ex_op1=10, ex_imm=7, ex_rd=5, ctrl.reg_write=1, alu_src_imm=1.
- LW x6,0(x2) accepted, then ADD x7,x6,x3 presented -> if_ready=0 for 1 cycle, one bubble (ex_valid=0), ADD issued the following cycle.
- ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, if_ready=0. Release -> next instruction issued.
- flush=1 while if_valid=1, ex_valid=1 -> if_ready=0, ex_valid=0 next cycle, instruction dropped.
- SW x0,4(x0) with rf_rdata2=0xDEADBEEF -> ex_op2=0, ex_imm=4. ADDI x0,x0,1 -> ctrl.reg_write=0. Opcode 0x7F -> ex_illegal=1.
- With DEC_WB_BYPASS_EN: wb_we=1, wb_rd=3, wb_data=0x55, rf_rdata2=0x11, OP rs2=x3 -> ex_op2=0x55. Without the macro -> 0x11.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encodings, control bundle, immediate formats.
package rv_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Branches use SUB for the compare; LUI passes the immediate straight through.
  localparam logic [ALU_OP_W-1:0] ALU_ADD      = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB      = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL      = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT      = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU     = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR      = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL      = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA      = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR       = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND      = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_IMM = 4'd10;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_imm;
    logic                op1_pc;
    logic                reg_write;
    logic                is_load;
    logic                is_store;
    logic                is_branch;
    logic                is_jump;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Sign-extended immediate for the given format; zero when the format has none.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // ALU operation from funct3; alt selects SUB/SRA where applicable.
  function automatic logic [ALU_OP_W-1:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: control bundle, immediate, source-use flags, illegal flag.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [31:0] imm,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  imm_fmt_e   fmt;
  ctrl_t      raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];

  // Opcode decode; unknown opcodes leave the control bundle all-zero.
  always_comb begin
    raw     = '0;
    fmt     = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        raw.alu_op      = ALU_PASS_IMM;
        raw.alu_src_imm = 1'b1;
        raw.reg_write   = 1'b1;
        fmt             = IMM_U;
      end
      OPC_AUIPC: begin
        raw.alu_op      = ALU_ADD;
        raw.alu_src_imm = 1'b1;
        raw.op1_pc      = 1'b1;
        raw.reg_write   = 1'b1;
        fmt             = IMM_U;
      end
      OPC_JAL: begin
        raw.alu_op      = ALU_ADD;
        raw.alu_src_imm = 1'b1;
        raw.op1_pc      = 1'b1;
        raw.reg_write   = 1'b1;
        raw.is_jump     = 1'b1;
        fmt             = IMM_J;
      end
      OPC_JALR: begin
        raw.alu_op      = ALU_ADD;
        raw.alu_src_imm = 1'b1;
        raw.reg_write   = 1'b1;
        raw.is_jump     = 1'b1;
        fmt             = IMM_I;
        use_rs1         = 1'b1;
      end
      OPC_BRANCH: begin
        raw.alu_op    = ALU_SUB;
        raw.is_branch = 1'b1;
        fmt           = IMM_B;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_LOAD: begin
        raw.alu_op      = ALU_ADD;
        raw.alu_src_imm = 1'b1;
        raw.reg_write   = 1'b1;
        raw.is_load     = 1'b1;
        fmt             = IMM_I;
        use_rs1         = 1'b1;
      end
      OPC_STORE: begin
        raw.alu_op      = ALU_ADD;
        raw.alu_src_imm = 1'b1;
        raw.is_store    = 1'b1;
        fmt             = IMM_S;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] is an immediate bit except for the SRLI/SRAI encoding.
        raw.alu_op      = alu_from_funct3(funct3, instr[30] & (funct3 == 3'b101));
        raw.alu_src_imm = 1'b1;
        raw.reg_write   = 1'b1;
        fmt             = IMM_I;
        use_rs1         = 1'b1;
      end
      OPC_OP: begin
        raw.alu_op    = alu_from_funct3(funct3, instr[30]);
        raw.reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Writes to x0 are suppressed here so later stages never see them.
  always_comb begin
    ctrl           = raw;
    ctrl.reg_write = raw.reg_write & (rd != 5'd0);
    imm            = imm_gen(instr, fmt);
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I ID stage: decode, operand fetch, load-use stall, flush and ID/EX register.
// Optional macro DEC_WB_BYPASS_EN forwards the writeback port into the operands.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output ctrl_t           ex_ctrl,
  output logic            ex_illegal
);

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  ctrl_t           dec_ctrl;
  logic [31:0]     dec_imm;
  logic            use_rs1;
  logic            use_rs2;
  logic            dec_illegal;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            pipe_ready;
  logic            load_use;
  logic            xfer;

  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  rv_decoder u_decoder (
    .instr   (if_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .illegal (dec_illegal)
  );

`ifndef DEC_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  // Operand select: optional writeback forward, then x0 forced to zero.
  always_comb begin
    op1 = rf_rdata1;
    op2 = rf_rdata2;
`ifdef DEC_WB_BYPASS_EN
    if (wb_we && (wb_rd == rs1)) op1 = wb_data;
    if (wb_we && (wb_rd == rs2)) op2 = wb_data;
`endif
    if (rs1 == 5'd0) op1 = '0;
    if (rs2 == 5'd0) op2 = '0;
  end

  // Load-use stall and IF handshake; flush refuses the presented instruction.
  assign pipe_ready = ex_ready | ~ex_valid;
  assign load_use   = ex_valid & ex_ctrl.is_load & ex_ctrl.reg_write & (ex_rd != 5'd0) &
                      (((ex_rd == rs1) & use_rs1) | ((ex_rd == rs2) & use_rs2));
  assign if_ready   = pipe_ready & ~load_use & ~flush;
  assign xfer       = if_valid & if_ready;

  // ID/EX register: bubble when EX can take data but nothing transfers, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (pipe_ready) begin
      ex_valid <= xfer;
      if (xfer) begin
        ex_pc      <= if_pc;
        ex_op1     <= op1;
        ex_op2     <= op2;
        ex_imm     <= XLEN'($signed(dec_imm));
        ex_rd      <= rd;
        ex_ctrl    <= dec_ctrl;
        ex_illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: instructions are built from fields by an encoder,
// expected ID/EX contents are queued on acceptance and checked when EX consumes them.
module tb_rv_decode_stage;
  import rv_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;
`ifdef DEC_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP, K_ILL} kind_e;

  typedef struct {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic [31:0] raw;
  } desc_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    ctrl_t           ctrl;
    logic            ill;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  ctrl_t           ex_ctrl;
  logic            ex_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   mon_en = 1'b0;

  // Reference state: what the ID/EX register should hold (valid, pending load dest).
  logic       m_valid = 1'b0, n_valid = 1'b0;
  logic       m_ld = 1'b0, n_ld = 1'b0;
  logic [4:0] m_rd = 5'd0, n_rd = 5'd0;
  logic       n_clear = 1'b0;

  rv_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input desc_t d);
    logic [31:0] i;
    i = d.imm;
    case (d.kind)
      K_LUI:   return {i[31:12], d.rd, 7'h37};
      K_AUIPC: return {i[31:12], d.rd, 7'h17};
      K_JAL:   return {i[20], i[10:1], i[11], i[19:12], d.rd, 7'h6F};
      K_JALR:  return {i[11:0], d.rs1, 3'b000, d.rd, 7'h67};
      K_BR:    return {i[12], i[10:5], d.rs2, d.rs1, d.f3, i[4:1], i[11], 7'h63};
      K_LD:    return {i[11:0], d.rs1, d.f3, d.rd, 7'h03};
      K_ST:    return {i[11:5], d.rs2, d.rs1, d.f3, i[4:0], 7'h23};
      K_OPI:   return {i[11:0], d.rs1, d.f3, d.rd, 7'h13};
      K_OP:    return {1'b0, d.alt, 5'b0, d.rs2, d.rs1, d.f3, d.rd, 7'h33};
      default: return d.raw;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ctrl_t exp_ctrl(input desc_t d, input logic [4:0] rd_field);
    ctrl_t c;
    c = '0;
    case (d.kind)
      K_LUI:   begin c.alu_op = ALU_PASS_IMM; c.alu_src_imm = 1; c.reg_write = 1; end
      K_AUIPC: begin c.alu_op = ALU_ADD; c.alu_src_imm = 1; c.op1_pc = 1; c.reg_write = 1; end
      K_JAL:   begin c.alu_op = ALU_ADD; c.alu_src_imm = 1; c.op1_pc = 1; c.reg_write = 1; c.is_jump = 1; end
      K_JALR:  begin c.alu_op = ALU_ADD; c.alu_src_imm = 1; c.reg_write = 1; c.is_jump = 1; end
      K_BR:    begin c.alu_op = ALU_SUB; c.is_branch = 1; end
      K_LD:    begin c.alu_op = ALU_ADD; c.alu_src_imm = 1; c.reg_write = 1; c.is_load = 1; end
      K_ST:    begin c.alu_op = ALU_ADD; c.alu_src_imm = 1; c.is_store = 1; end
      K_OPI:   begin c.alu_op = alu_of(d.f3, d.alt && d.f3 == 3'd5); c.alu_src_imm = 1; c.reg_write = 1; end
      K_OP:    begin c.alu_op = alu_of(d.f3, d.alt); c.reg_write = 1; end
      default: c = '0;
    endcase
    if (rd_field == 5'd0) c.reg_write = 1'b0;
    return c;
  endfunction

  function automatic desc_t mk(input kind_e k, input int rd, input int rs1, input int rs2,
                               input int f3, input logic [31:0] imm);
    desc_t d;
    d.kind = k; d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    d.f3 = 3'(f3); d.alt = 1'b0; d.imm = imm; d.raw = 32'h0;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom;
    d.kind = kind_e'($urandom_range(0, 9));
    d.rd   = 5'($urandom_range(0, 7));
    d.rs1  = 5'($urandom_range(0, 7));
    d.rs2  = 5'($urandom_range(0, 7));
    d.f3   = 3'($urandom);
    d.alt  = 1'($urandom);
    d.raw  = r;
    case (d.kind)
      K_LUI, K_AUIPC: d.imm = {r[31:12], 12'b0};
      K_JAL:          d.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BR:           d.imm = {{19{r[12]}}, r[12:1], 1'b0};
      K_OP:           d.imm = 32'h0;
      K_OPI: begin
        if (d.f3 == 3'd1)      begin d.alt = 1'b0; d.imm = {27'b0, r[4:0]}; end
        else if (d.f3 == 3'd5) d.imm = {21'b0, d.alt, 5'b0, r[4:0]};
        else                   begin d.alt = 1'b0; d.imm = {{20{r[11]}}, r[11:0]}; end
      end
      K_ILL: begin
        do opc = 7'($urandom);
        while (opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
        d.raw = {r[31:7], opc};
        d.imm = 32'h0;
      end
      default: d.imm = {{20{r[11]}}, r[11:0]};
    endcase
    if (d.kind == K_JALR) d.f3 = 3'd0;
    return d;
  endfunction

  // One clock of stimulus: commit the reference state, drive inputs, predict if_ready and transfer.
  task automatic step(input logic rst, input logic v, input desc_t d, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wdat, input logic exr,
                      input logic fl);
    logic [31:0] instr;
    logic [4:0]  s1, s2;
    logic        u1, u2, hz, prdy, erdy, xf;
    exp_t        e;
    @(posedge clk);
    #1;
    m_valid = n_valid; m_ld = n_ld; m_rd = n_rd;
    if (n_clear) q.delete();
    instr = encode(d);
    reset = rst; if_valid = v; if_instr = instr; if_pc = pc;
    rf_rdata1 = d1; rf_rdata2 = d2; wb_we = we; wb_rd = wrd; wb_data = wdat;
    ex_ready = exr; flush = fl;
    #2;
    s1 = instr[19:15];
    s2 = instr[24:20];
    u1 = d.kind inside {K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP};
    u2 = d.kind inside {K_BR, K_ST, K_OP};
    hz   = m_valid && m_ld && ((m_rd == s1 && u1) || (m_rd == s2 && u2));
    prdy = exr || !m_valid;
    erdy = prdy && !hz && !fl;
    if (mon_en) begin
      check("if_ready", 64'(if_ready), 64'(erdy));
      check("rf_rs1", 64'(rf_rs1), 64'(s1));
      check("rf_rs2", 64'(rf_rs2), 64'(s2));
    end
    xf = v && erdy && !rst;
    n_clear = rst;
    if (rst || fl) n_valid = 1'b0;
    else if (prdy)  n_valid = xf;
    else            n_valid = m_valid;
    if (xf) begin
      e.pc   = pc;
      e.op1  = (s1 == 0) ? 32'h0 : (BYP && we && wrd == s1) ? wdat : d1;
      e.op2  = (s2 == 0) ? 32'h0 : (BYP && we && wrd == s2) ? wdat : d2;
      e.imm  = (d.kind inside {K_OP, K_ILL}) ? 32'h0 : d.imm;
      e.rd   = instr[11:7];
      e.ctrl = exp_ctrl(d, instr[11:7]);
      e.ill  = (d.kind == K_ILL);
      q.push_back(e);
      n_ld = (d.kind == K_LD) && (instr[11:7] != 5'd0);
      n_rd = instr[11:7];
    end else begin
      n_ld = m_ld;
      n_rd = m_rd;
    end
  endtask

  // Monitor: ex_valid against the reference every cycle, payload whenever EX takes or drops it.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("ex_valid", 64'(ex_valid), 64'(m_valid));
      if (ex_valid && (ex_ready || flush)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ex_unexpected actual=valid required=empty @%0t", $time);
        end else begin
          e = q.pop_front();
          check("ex_pc", 64'(ex_pc), 64'(e.pc));
          check("ex_op1", 64'(ex_op1), 64'(e.op1));
          check("ex_op2", 64'(ex_op2), 64'(e.op2));
          check("ex_imm", 64'(ex_imm), 64'(e.imm));
          check("ex_rd", 64'(ex_rd), 64'(e.rd));
          check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
          check("ex_illegal", 64'(ex_illegal), 64'(e.ill));
        end
      end
    end
  end

  initial begin
    desc_t nop, d;
    nop = mk(K_OPI, 0, 0, 0, 0, 32'h0);
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;

    step(1, 0, nop, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, nop, 32'h44, 0, 0, 0, 0, 0, 1, 0);
    check("rst_ex_valid", 64'(ex_valid), 64'h0);
    check("rst_ex_pc", 64'(ex_pc), 64'h0);
    check("rst_ex_op1", 64'(ex_op1), 64'h0);
    check("rst_ex_op2", 64'(ex_op2), 64'h0);
    check("rst_ex_imm", 64'(ex_imm), 64'h0);
    check("rst_ex_rd", 64'(ex_rd), 64'h0);
    check("rst_ex_ctrl", 64'(ex_ctrl), 64'h0);
    check("rst_ex_illegal", 64'(ex_illegal), 64'h0);
    mon_en = 1'b1;

    // ADDI x5,x1,7 with rs1 data 10
    step(0, 1, mk(K_OPI, 5, 1, 0, 0, 32'd7), 32'h100, 32'd10, 32'd0, 0, 0, 0, 1, 0);
    // LW x6,0(x2) then ADD x7,x6,x3: one stall cycle, then ADD goes
    step(0, 1, mk(K_LD, 6, 2, 0, 2, 32'd0), 32'h104, 32'h20, 32'h0, 0, 0, 0, 1, 0);
    step(0, 1, mk(K_OP, 7, 6, 3, 0, 32'd0), 32'h108, 32'h66, 32'h33, 0, 0, 0, 1, 0);
    step(0, 1, mk(K_OP, 7, 6, 3, 0, 32'd0), 32'h108, 32'h66, 32'h33, 0, 0, 0, 1, 0);
    step(0, 0, nop, 0, 0, 0, 0, 0, 0, 1, 0);
    // EX back-pressure for three cycles
    step(0, 1, mk(K_OPI, 1, 2, 0, 0, 32'd3), 32'h200, 32'h5, 32'h0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, mk(K_OPI, 8, 9, 0, 0, 32'hFFFF_FFFF), 32'h204, 32'h9, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, mk(K_OPI, 8, 9, 0, 0, 32'hFFFF_FFFF), 32'h204, 32'h9, 32'h0, 0, 0, 0, 1, 0);
    // flush with a valid IF instruction and a valid ID/EX entry
    step(0, 1, mk(K_OPI, 4, 4, 0, 0, 32'd1), 32'h300, 32'h1, 32'h0, 0, 0, 0, 1, 1);
    step(0, 0, nop, 0, 0, 0, 0, 0, 0, 1, 0);
    // SW x0,4(x0); ADDI x0,x0,1; illegal opcode 0x7F
    step(0, 1, mk(K_ST, 0, 0, 0, 2, 32'd4), 32'h400, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
    step(0, 1, mk(K_OPI, 0, 0, 0, 0, 32'd1), 32'h404, 32'h7, 32'h7, 0, 0, 0, 1, 0);
    d = mk(K_ILL, 0, 0, 0, 0, 32'h0);
    d.raw = 32'h1234_567F;
    step(0, 1, d, 32'h408, 32'h1, 32'h2, 0, 0, 0, 1, 0);
    // writeback port targeting rs2 of an OP instruction
    step(0, 1, mk(K_OP, 1, 2, 3, 0, 32'd0), 32'h40C, 32'h22, 32'h11, 1, 5'd3, 32'h55, 1, 0);
    step(0, 0, nop, 0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), rand_desc(),
           $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0));
    end

    for (int i = 0; i < 4; i++) step(0, 0, nop, 0, 0, 0, 0, 0, 0, 1, 0);
    check("queue_drained", 64'(q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
